// File: rtl/ibex_rf_pkg.sv
// Shared definitions for the multi-port register file: address widths,
// word-count helper and the architectural address type.
package ibex_rf_pkg;

    localparam int unsigned RF_ADDR_W_I = 5;
    localparam int unsigned RF_ADDR_W_E = 4;

    typedef logic [4:0] rf_addr_t;

    // Number of architectural registers for the selected base ISA.
    function automatic int unsigned rf_num_words(input bit rv32e);
        return rv32e ? 32'd16 : 32'd32;
    endfunction

endpackage

// File: rtl/ibex_rf_access_counter.sv
// Saturating per-register access counter; clear beats increment.
module ibex_rf_access_counter
    import ibex_rf_pkg::*;
#(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             hit_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_reg;

    // Count one access per cycle, holding at all-ones instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_reg <= '0;
        end else if (clr_i) begin
            cnt_reg <= '0;
        end else if (hit_i && en_i && (cnt_reg != {Width{1'b1}})) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt_o = cnt_reg;

endmodule

// File: rtl/ibex_register_file_mp.sv
// Flip-flop register file with configurable read/write ports, optional
// write-to-read forwarding, a dummy-instruction R0 and per-register
// saturating access counters exposed through a registered debug port.
module ibex_register_file_mp
    import ibex_rf_pkg::*;
#(
    parameter bit          RV32E             = 1'b0,
    parameter int unsigned DataWidth         = 32,
    parameter int unsigned NumRead           = 2,
    parameter int unsigned NumWrite          = 1,
    parameter bit          BypassEn          = 1'b0,
    parameter bit          DummyInstructions = 1'b0,
    parameter int unsigned CountWidth        = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          test_en_i,
    input  logic                          dummy_instr_id_i,
    input  logic [NumRead*5-1:0]          raddr_i,
    input  logic [NumRead-1:0]            re_i,
    output logic [NumRead*DataWidth-1:0]  rdata_o,
    input  logic [NumWrite*5-1:0]         waddr_i,
    input  logic [NumWrite*DataWidth-1:0] wdata_i,
    input  logic [NumWrite-1:0]           we_i,
    input  logic                          cnt_en_i,
    input  logic                          cnt_clr_i,
    input  logic [4:0]                    cnt_addr_i,
    output logic [CountWidth-1:0]         cnt_rdata_o
);

    localparam int unsigned NUM_WORDS = rf_num_words(RV32E);
    localparam int unsigned ADDR_W    = RV32E ? RF_ADDR_W_E : RF_ADDR_W_I;

    // Port buses split into per-port fields; upper address bit dropped for RV32E.
    logic [ADDR_W-1:0]    raddr_w [NumRead];
    logic [ADDR_W-1:0]    waddr_w [NumWrite];
    logic [DataWidth-1:0] wdata_w [NumWrite];

    // Read view of every word; word 0 already resolved to zero or R0.
    logic [NUM_WORDS-1:0][DataWidth-1:0]  rf_words;
    logic [NUM_WORDS-1:0][CountWidth-1:0] cnt_all;
    logic [DataWidth-1:0]                 rf_r0;
    logic [CountWidth-1:0]                cnt_rdata_reg;
    rf_addr_t                             cnt_sel;

    genvar gi;

    for (gi = 0; gi < NumRead; gi++) begin : g_raddr
        assign raddr_w[gi] = raddr_i[gi*5 +: ADDR_W];
    end

    for (gi = 0; gi < NumWrite; gi++) begin : g_wport
        assign waddr_w[gi] = waddr_i[gi*5 +: ADDR_W];
        assign wdata_w[gi] = wdata_i[gi*DataWidth +: DataWidth];
    end

    // R0 only exists as storage when dummy instructions are enabled.
    if (DummyInstructions) begin : g_r0
        logic r0_we;
        assign r0_we = we_i[0] & dummy_instr_id_i & (waddr_w[0] == '0);

        // Capture write port 0 into R0 for dummy instructions only.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                rf_r0 <= '0;
            end else if (r0_we) begin
                rf_r0 <= wdata_w[0];
            end
        end
    end else begin : g_no_r0
        assign rf_r0 = '0;
    end

    assign rf_words[0] = (DummyInstructions && dummy_instr_id_i) ? rf_r0 : '0;

    // General-purpose registers x1..xN-1.
    for (gi = 1; gi < NUM_WORDS; gi++) begin : g_reg
        logic                 wen;
        logic [DataWidth-1:0] wdat;
        logic [DataWidth-1:0] word_reg;

        // Write decode: later (higher-index) ports override earlier ones.
        always_comb begin
            wen  = 1'b0;
            wdat = '0;
            for (int w = 0; w < NumWrite; w++) begin
                if (we_i[w] && (waddr_w[w] == ADDR_W'(gi))) begin
                    wen  = 1'b1;
                    wdat = wdata_w[w];
                end
            end
        end

        // Storage for this register.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                word_reg <= '0;
            end else if (wen) begin
                word_reg <= wdat;
            end
        end

        assign rf_words[gi] = word_reg;
    end

    // Read ports, with optional same-cycle forwarding of write data.
    for (gi = 0; gi < NumRead; gi++) begin : g_rd
        logic [DataWidth-1:0] rd_data;

        // Stored value by default; matching enabled writes override when forwarding.
        always_comb begin
            rd_data = rf_words[raddr_w[gi]];
            if (BypassEn && (raddr_w[gi] != '0)) begin
                for (int w = 0; w < NumWrite; w++) begin
                    if (we_i[w] && (waddr_w[w] == raddr_w[gi])) begin
                        rd_data = wdata_w[w];
                    end
                end
            end
        end

        assign rdata_o[gi*DataWidth +: DataWidth] = rd_data;
    end

    // One access counter per register, R0 included.
    for (gi = 0; gi < NUM_WORDS; gi++) begin : g_cnt
        logic hit;

        // A register is hit by any valid read or any enabled write naming it.
        always_comb begin
            hit = 1'b0;
            for (int p = 0; p < NumRead; p++) begin
                if (re_i[p] && (raddr_w[p] == ADDR_W'(gi))) begin
                    hit = 1'b1;
                end
            end
            for (int w = 0; w < NumWrite; w++) begin
                if (we_i[w] && (waddr_w[w] == ADDR_W'(gi))) begin
                    hit = 1'b1;
                end
            end
        end

        ibex_rf_access_counter #(
            .Width (CountWidth)
        ) u_cnt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .hit_i  (hit),
            .en_i   (cnt_en_i),
            .clr_i  (cnt_clr_i),
            .cnt_o  (cnt_all[gi])
        );
    end

    assign cnt_sel = cnt_addr_i;

    // Debug read of the selected counter, sampled before this edge's update.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_rdata_reg <= '0;
        end else begin
            cnt_rdata_reg <= cnt_all[cnt_sel[ADDR_W-1:0]];
        end
    end

    assign cnt_rdata_o = cnt_rdata_reg;

    // Test-mode input and aliased upper address bits are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{test_en_i, raddr_i, waddr_i, cnt_sel};

endmodule

// File: tb/tb_ibex_register_file_mp.sv
// Self-checking bench: two register-file variants (forwarding+dummy R0, and
// plain) driven by shared stimulus and compared with a behavioural model.
module tb_ibex_register_file_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dummy;
    logic [4:0]  ra [2];
    logic [1:0]  re;
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic [1:0]  we;
    logic        cnt_en, cnt_clr;
    logic [4:0]  caddr;

    logic [9:0]  raddr_bus;
    logic [9:0]  waddr_bus;
    logic [63:0] wdata_bus;
    logic [63:0] rdata_a, rdata_b;
    logic [3:0]  cnt_a, cnt_b;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state
    logic [31:0] mem [32];
    logic [31:0] r0m;
    int          cntm [32];
    int          cnt_rd_m;

    assign raddr_bus = {ra[1], ra[0]};
    assign waddr_bus = {wa[1], wa[0]};
    assign wdata_bus = {wd[1], wd[0]};

    always #5 clk = ~clk;

    ibex_register_file_mp #(
        .RV32E(1'b0), .DataWidth(32), .NumRead(2), .NumWrite(2),
        .BypassEn(1'b1), .DummyInstructions(1'b1), .CountWidth(4)
    ) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b0), .dummy_instr_id_i(dummy),
        .raddr_i(raddr_bus), .re_i(re), .rdata_o(rdata_a),
        .waddr_i(waddr_bus), .wdata_i(wdata_bus), .we_i(we),
        .cnt_en_i(cnt_en), .cnt_clr_i(cnt_clr), .cnt_addr_i(caddr), .cnt_rdata_o(cnt_a)
    );

    ibex_register_file_mp #(
        .RV32E(1'b0), .DataWidth(32), .NumRead(2), .NumWrite(2),
        .BypassEn(1'b0), .DummyInstructions(1'b0), .CountWidth(4)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b0), .dummy_instr_id_i(dummy),
        .raddr_i(raddr_bus), .re_i(re), .rdata_o(rdata_b),
        .waddr_i(waddr_bus), .wdata_i(wdata_bus), .we_i(we),
        .cnt_en_i(cnt_en), .cnt_clr_i(cnt_clr), .cnt_addr_i(caddr), .cnt_rdata_o(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input int a, input bit fwd, input bit has_r0);
        logic [31:0] v;
        if (a == 0) return (has_r0 && dummy) ? r0m : 32'h0;
        v = mem[a];
        if (fwd) begin
            for (int w = 0; w < 2; w++)
                if (we[w] && wa[w] == a[4:0]) v = wd[w];
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mem[i]  = 32'h0;
            cntm[i] = 0;
        end
        r0m      = 32'h0;
        cnt_rd_m = 0;
    endtask

    // Apply the register-file rules for one clock edge.
    task automatic model_edge();
        bit acc [32];
        cnt_rd_m = cntm[caddr];
        for (int i = 0; i < 32; i++) acc[i] = 1'b0;
        for (int p = 0; p < 2; p++) if (re[p]) acc[ra[p]] = 1'b1;
        for (int w = 0; w < 2; w++) if (we[w]) acc[wa[w]] = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (cnt_clr) cntm[i] = 0;
            else if (acc[i] && cnt_en && cntm[i] < 15) cntm[i] = cntm[i] + 1;
        end
        for (int w = 0; w < 2; w++) begin
            if (we[w]) begin
                if (wa[w] != 0) mem[wa[w]] = wd[w];
                else if (w == 0 && dummy) r0m = wd[0];
            end
        end
    endtask

    // One transaction: check reads mid-cycle, step the edge, check counter port.
    task automatic cycle();
        #1;
        chk("rd_a_p0", rdata_a[31:0],  model_read(ra[0], 1'b1, 1'b1));
        chk("rd_a_p1", rdata_a[63:32], model_read(ra[1], 1'b1, 1'b1));
        chk("rd_b_p0", rdata_b[31:0],  model_read(ra[0], 1'b0, 1'b0));
        chk("rd_b_p1", rdata_b[63:32], model_read(ra[1], 1'b0, 1'b0));
        @(posedge clk);
        model_edge();
        #1;
        chk("cnt_a", {28'h0, cnt_a}, cnt_rd_m[31:0]);
        chk("cnt_b", {28'h0, cnt_b}, cnt_rd_m[31:0]);
        $display("txn t=%0t ra=%0d/%0d re=%b wa=%0d/%0d we=%b dummy=%b en=%b clr=%b caddr=%0d rd_a=%h rd_b=%h cnt=%0d",
                 $time, ra[0], ra[1], re, wa[0], wa[1], we, dummy, cnt_en, cnt_clr, caddr,
                 rdata_a, rdata_b, cnt_a);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ra[0] = 0; ra[1] = 0; re = 0; wa[0] = 0; wa[1] = 0;
        wd[0] = 0; wd[1] = 0; we = 0; dummy = 0;
        cnt_en = 0; cnt_clr = 0; caddr = 0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        #12;
        chk("reset_rd_a", rdata_a[31:0], 32'h0);
        chk("reset_rd_b", rdata_b[63:32], 32'h0);
        chk("reset_cnt_a", {28'h0, cnt_a}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // x5 write, then dual read
        we = 2'b01; wa[0] = 5; wd[0] = 32'hDEADBEEF;
        cycle();
        idle_inputs(); ra[0] = 5; ra[1] = 5;
        #1;
        chk("x5_p0", rdata_b[31:0], 32'hDEADBEEF);
        chk("x5_p1", rdata_b[63:32], 32'hDEADBEEF);
        cycle();
        idle_inputs();
        cycle();

        // Both ports to x7: port 1 wins
        we = 2'b11; wa[0] = 7; wd[0] = 32'h11111111; wa[1] = 7; wd[1] = 32'h22222222;
        cycle();
        idle_inputs(); ra[0] = 7;
        #1 chk("x7_prio", rdata_b[31:0], 32'h22222222);
        cycle();

        // Forwarding vs. no forwarding on x3
        idle_inputs(); we = 2'b01; wa[0] = 3; wd[0] = 32'hA5A5A5A5; ra[0] = 3;
        #1;
        chk("x3_fwd", rdata_a[31:0], 32'hA5A5A5A5);
        chk("x3_nofwd_old", rdata_b[31:0], 32'h0);
        cycle();
        idle_inputs(); ra[0] = 3;
        #1 chk("x3_nofwd_new", rdata_b[31:0], 32'hA5A5A5A5);
        cycle();

        // Dummy-instruction R0
        idle_inputs(); we = 2'b01; wa[0] = 0; wd[0] = 32'h1234; dummy = 1;
        cycle();
        idle_inputs(); dummy = 1;
        #1;
        chk("r0_dummy", rdata_a[31:0], 32'h1234);
        chk("r0_plain_variant", rdata_b[31:0], 32'h0);
        cycle();
        idle_inputs();
        #1 chk("r0_nondummy", rdata_a[31:0], 32'h0);
        cycle();

        // Counter saturation on x9
        idle_inputs(); cnt_clr = 1;
        cycle();
        idle_inputs(); ra[0] = 9; ra[1] = 9; re = 2'b11; cnt_en = 1; caddr = 9;
        for (int i = 0; i < 20; i++) cycle();
        chk("cnt9_sat", {28'h0, cnt_a}, 32'hF);
        cnt_clr = 1;
        cycle();
        cnt_clr = 0; re = 2'b00;
        cycle();
        chk("cnt9_clr", {28'h0, cnt_a}, 32'h0);

        // Latency: counter at 5, access in the sampling cycle
        re = 2'b11;
        for (int i = 0; i < 5; i++) cycle();
        cycle();
        chk("cnt9_pre", {28'h0, cnt_a}, 32'd5);
        re = 2'b00;
        cycle();
        chk("cnt9_post", {28'h0, cnt_a}, 32'd6);

        // Randomised traffic with a reset in the middle
        for (int i = 0; i < 300; i++) begin
            ra[0] = 5'($urandom_range(0, 31)); ra[1] = 5'($urandom_range(0, 31));
            wa[0] = 5'($urandom_range(0, 31)); wa[1] = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) wa[1] = ra[0];
            wd[0] = $urandom; wd[1] = $urandom;
            re = 2'($urandom); we = 2'($urandom);
            dummy = 1'($urandom); cnt_en = ($urandom_range(0, 7) != 0);
            cnt_clr = ($urandom_range(0, 31) == 0);
            caddr = 5'($urandom_range(0, 31));
            if (i == 150) begin
                we = 2'b00;
                rst_n = 1'b0;
                model_reset();
                #1;
                chk("midrst_cnt", {28'h0, cnt_a}, 32'h0);
                chk("midrst_rd_a", rdata_a[31:0], model_read(ra[0], 1'b1, 1'b1));
                chk("midrst_rd_b", rdata_b[63:32], model_read(ra[1], 1'b0, 1'b0));
                @(negedge clk);
                rst_n = 1'b1;
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ibex_register_file_mp.md
Name: ibex_register_file_mp

Overview:
- Flip-flop register file, parametrised successor of the single-write / dual-read Ibex RF.
- Configurable read and write port counts, optional write-to-read bypass, dummy-instruction R0.
- Per-register saturating access counters, readable through a registered debug port; used for register-usage profiling.
- Sits in the ID stage in place of the standard register file; the core instantiates it with NumRead=2, NumWrite=1.

Parameters:
- RV32E, 0, 1 -> 16 registers (ADDR_WIDTH=4), 0 -> 32 registers (ADDR_WIDTH=5)
- DataWidth, 32, register width in bits
- NumRead, 2, read ports (1..4)
- NumWrite, 1, write ports (1..2)
- BypassEn, 0, 1 -> same-cycle write data is forwarded to matching reads
- DummyInstructions, 0, 1 -> R0 is a real register visible only to dummy instructions
- CountWidth, 16, width of each access counter

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- test_en_i  in  1  test mode; unused, tie-off only
- dummy_instr_id_i  in  1  current ID instruction is a dummy
- raddr_i  in  NumRead*5  read addresses; port p at bits [5p+4:5p]
- re_i  in  NumRead  read valid per port; affects counters only
- rdata_o  out  NumRead*DataWidth  read data per port
- waddr_i  in  NumWrite*5  write addresses
- wdata_i  in  NumWrite*DataWidth  write data
- we_i  in  NumWrite  write enables
- cnt_en_i  in  1  counter increment enable
- cnt_clr_i  in  1  synchronous clear of all counters
- cnt_addr_i  in  5  counter select
- cnt_rdata_o  out  CountWidth  selected counter value, registered

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on rst_ni. All registers, counters, rf_r0 and cnt_rdata_o reset to 0.
- Address width: only the low ADDR_WIDTH bits of every address are used. When RV32E=1, bit 4 is ignored; addresses 16..31 alias 0..15.
- Writes: a write to register r (r != 0) takes effect at the clock edge when we_i[w] is set and waddr_i[w] equals r. If both write ports target the same r in one cycle, the higher port index wins.
- R0 writes: ignored unless DummyInstructions=1, we_i[0]=1 and dummy_instr_id_i=1; then wdata_i[0] is stored in rf_r0.
- Reads: combinational, zero latency, and independent of re_i.
  - Address 0 returns 0, or rf_r0 when DummyInstructions=1 and dummy_instr_id_i=1.
  - With BypassEn=1, a read of r != 0 returns the same-cycle write data when a write to r is enabled, using the same priority rule as writes. R0 is never bypassed.
  - With BypassEn=0, a read returns the stored value; new data is visible in the next cycle.
- Counters: one counter per register, including R0, CountWidth bits wide.
  - Register r is "accessed" in a cycle if any port with re_i set reads r, or any enabled write targets r.
  - When accessed and cnt_en_i=1, the counter increments by exactly 1, even if several ports hit r. It saturates at all-ones and never wraps.
  - cnt_clr_i has priority over increment: all counters read 0 after the edge, and that cycle's accesses are not counted.
- Counter read: cnt_rdata_o is registered with 1-cycle latency. It holds the value of counter cnt_addr_i sampled at the edge, before that edge's update, so it is the pre-increment value.
- Reset mid-operation: all state returns to 0 immediately; outputs are valid from the first rising edge after release.

Decomposition:
- Package ibex_rf_pkg:
  - localparams RF_ADDR_W_I=5 and RF_ADDR_W_E=4.
  - Function rf_num_words(rv32e).
  - Typedef rf_addr_t (logic [4:0]).
- Sub-module ibex_rf_access_counter, one instance per register:
  - Inputs: clk_i, rst_ni, hit_i, en_i, clr_i.
  - Output: cnt_o.
  - Behaviour: saturating counter with clear priority.
- The top level keeps the write decode, the bypass muxes and the counter read register.

Test Plan:
- Reset, then write 0xDEADBEEF to x5 via port 0, read x5 on ports 0 and 1 next cycle -> both return 0xDEADBEEF, and x0 reads 0.
- NumWrite=2, both ports write x7 in one cycle (0x11111111 on port 0, 0x22222222 on port 1) -> x7 = 0x22222222.
- BypassEn=1, write x3=0xA5A5A5A5 while reading x3 in the same cycle -> rdata = 0xA5A5A5A5 in that cycle. With BypassEn=0 -> old value that cycle, new value the next cycle.
- DummyInstructions=1, write 0x1234 to x0 with dummy_instr_id_i=1, then read x0 -> 0x1234 with dummy_instr_id_i=1 and 0 with dummy_instr_id_i=0.
- Counters, CountWidth=4, cnt_en_i=1:
  - Read x9 on two ports for 20 cycles -> counter 9 = 0xF (saturated, one increment per cycle).
  - Assert cnt_clr_i with a concurrent x9 access -> counter 9 = 0.
- Counter read latency: set cnt_addr_i=9 with counter 9 at 5 while x9 is accessed in the same cycle -> cnt_rdata_o = 5 after the edge, and 6 after the following edge.
